// File: rtl/pipe_hazard_ctrl_if.sv
// Interlock bus between the pipeline datapath and the hazard controller.
// The datapath side drives the ID/EX hazard inputs; the controller drives the enables and debug state.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      id_ir;
  logic             ex_mem_rd;
  logic [4:0]       ex_wa;
  logic             ex_br_taken;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             md_start;
  logic             md_busy;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_ir, ex_mem_rd, ex_wa, ex_br_taken,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, md_start, md_busy,
           state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_ir, ex_mem_rd, ex_wa, ex_br_taken,
    output pc_we, ifid_we, ifid_flush, idex_bubble, md_start, md_busy,
           state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline interlock controller: load-use and mult/div stalls, taken-branch flush,
// mult/div busy tracking and saturating stall/flush statistics.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_LAT = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned MD_W = 8;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LD_STALL = 2'd1,
    S_MD_WAIT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [MD_W-1:0]    r_md_cnt;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  logic [5:0] w_op;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [5:0] w_funct;
  logic       w_rtype;
  logic       w_uses_rs;
  logic       w_uses_rt;
  logic       w_is_md;
  logic       w_is_mf;
  logic       w_md_busy;
  logic       w_lu_haz;
  logic       w_md_haz;
  logic       w_stall;
  logic       w_md_start;

  // Instruction decode of the ID-stage IR
  assign w_op    = bus.id_ir[31:26];
  assign w_rs    = bus.id_ir[25:21];
  assign w_rt    = bus.id_ir[20:16];
  assign w_funct = bus.id_ir[5:0];
  assign w_rtype = (w_op == 6'h00);

  assign w_uses_rs = !(w_op == 6'h02 || w_op == 6'h03 || w_op == 6'h0F) &&
                     !(w_rtype && (w_funct == 6'h00 || w_funct == 6'h02 || w_funct == 6'h03));
  assign w_uses_rt = (w_op == 6'h00) || (w_op == 6'h04) || (w_op == 6'h05) || (w_op == 6'h2B);
  assign w_is_md   = w_rtype && (w_funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});
  assign w_is_mf   = w_rtype && (w_funct inside {6'h10, 6'h12});

  // $0 is never a real producer, so ex_wa == 0 cannot create a dependence
  assign w_md_busy  = (r_md_cnt != '0);
  assign w_lu_haz   = bus.ex_mem_rd && (bus.ex_wa != 5'd0) &&
                      ((w_uses_rs && (w_rs == bus.ex_wa)) || (w_uses_rt && (w_rt == bus.ex_wa)));
  assign w_md_haz   = w_md_busy && (w_is_md || w_is_mf);
  assign w_stall    = !bus.ex_br_taken && (w_lu_haz || w_md_haz);
  assign w_md_start = w_is_md && !w_stall && !bus.ex_br_taken;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: flush wins, then load-use, then mult/div wait
  always_comb begin
    w_state_nxt = S_RUN;
    if (bus.ex_br_taken) begin
      w_state_nxt = S_RUN;
    end else if (w_lu_haz) begin
      w_state_nxt = S_LD_STALL;
    end else if (w_md_haz) begin
      w_state_nxt = S_MD_WAIT;
    end
  end

  // Pipeline control outputs
  always_comb begin
    bus.pc_we       = 1'b1;
    bus.ifid_we     = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    if (bus.ex_br_taken) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
    end else if (w_stall) begin
      bus.pc_we       = 1'b0;
      bus.ifid_we     = 1'b0;
      bus.idex_bubble = 1'b1;
    end
    bus.md_start  = w_md_start;
    bus.md_busy   = w_md_busy;
    bus.state     = r_state;
    bus.stall_cnt = r_stall_cnt;
    bus.flush_cnt = r_flush_cnt;
  end

  // Mult/div busy countdown
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_md_cnt <= '0;
    end else if (w_md_start) begin
      r_md_cnt <= MD_W'(MD_LAT);
    end else if (w_md_busy) begin
      r_md_cnt <= r_md_cnt - MD_W'(1);
    end
  end

  // Saturating debug statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (bus.ex_br_taken && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
